// File: rtl/stack_alu_seq_pkg.sv
// Shared definitions for the stack ALU sequencer: stack command encodings,
// opcode values, FSM state type and opcode classification/legality helpers.
package stack_alu_seq_pkg;

    localparam logic [3:0] SA_IDLE = 4'b0000;
    localparam logic [3:0] SA_PUSH = 4'b1000;
    localparam logic [3:0] SA_POP  = 4'b0001;
    localparam logic [3:0] SA_DUP  = 4'b0101;
    localparam logic [3:0] SA_SWAP = 4'b0111;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_SHL1  = 4'h6;
    localparam logic [3:0] OP_SHR1  = 4'h7;
    localparam logic [3:0] OP_DUP   = 4'h8;
    localparam logic [3:0] OP_SWAP  = 4'h9;
    localparam logic [3:0] OP_DROP  = 4'hA;
    localparam logic [3:0] OP_PUSHI = 4'hB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_A,
        S_WAIT_A,
        S_POP_B,
        S_WAIT_B,
        S_ISSUE,
        S_WAIT_R
    } state_e;

    function automatic logic is_binary(input logic [3:0] op);
        return op <= OP_XOR;
    endfunction

    function automatic logic is_unary(input logic [3:0] op);
        return (op >= OP_NOT) && (op <= OP_SHR1);
    endfunction

    // True when the op cannot run at the given occupancy d of a stack of
    // capacity cap.
    function automatic logic op_reject(input logic [3:0] op,
                                       input int unsigned d,
                                       input int unsigned cap);
        logic r;
        r = 1'b0;
        if (is_binary(op) || op == OP_SWAP) r = (d < 2);
        else if (is_unary(op) || op == OP_DROP) r = (d < 1);
        else if (op == OP_DUP) r = (d < 1) || (d == cap);
        else if (op == OP_PUSHI) r = (d == cap);
        else r = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/stack_alu_seq_core.sv
// Combinational result datapath: a = latched top, b = latched next.
// Ports: a, b, op_code in; result out (modulo 2^DATA_WIDTH).
module stack_alu_core
    import stack_alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            op_code,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op_code)
            OP_ADD:  result = b + a;
            OP_SUB:  result = b - a;
            OP_AND:  result = b & a;
            OP_OR:   result = b | a;
            OP_XOR:  result = b ^ a;
            OP_NOT:  result = ~a;
            OP_SHL1: result = a << 1;
            OP_SHR1: result = a >> 1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stack_alu_seq.sv
// Sequencer driving an external stack: pops operands, pushes ALU results,
// tracks occupancy and rejects illegal requests.
// Ports: clk, rst (sync, high); op_valid/op_ready/op_code/op_imm request;
// top/next from stack; in_val/stackAction to stack; done, err, depth.
module stack_alu_seq
    import stack_alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [3:0]                   op_code,
    input  logic [DATA_WIDTH-1:0]        op_imm,
    input  logic [DATA_WIDTH-1:0]        top,
    input  logic [DATA_WIDTH-1:0]        next,
    output logic [DATA_WIDTH-1:0]        in_val,
    output logic [3:0]                   stackAction,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    localparam int DW = $clog2(DEPTH+1);

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] result;

    stack_alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .a       (a_q),
        .b       (b_q),
        .op_code (op_q),
        .result  (result)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_d       = imm_q;
        err_d       = 1'b0;
        stackAction = SA_IDLE;
        in_val      = '0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    if (op_reject(op_code, int'(depth_q), DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        op_d  = op_code;
                        a_d   = top;
                        b_d   = next;
                        imm_d = op_imm;
                        if (is_binary(op_code) || is_unary(op_code))
                            state_d = S_POP_A;
                        else
                            state_d = S_ISSUE;
                    end
                end
            end
            S_POP_A: begin
                stackAction = SA_POP;
                state_d     = S_WAIT_A;
            end
            S_WAIT_A: begin
                state_d = is_binary(op_q) ? S_POP_B : S_ISSUE;
            end
            S_POP_B: begin
                stackAction = SA_POP;
                state_d     = S_WAIT_B;
            end
            S_WAIT_B: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                case (op_q)
                    OP_DUP:  stackAction = SA_DUP;
                    OP_SWAP: stackAction = SA_SWAP;
                    OP_DROP: stackAction = SA_POP;
                    OP_PUSHI: begin
                        stackAction = SA_PUSH;
                        in_val      = imm_q;
                    end
                    default: begin
                        stackAction = SA_PUSH;
                        in_val      = result;
                    end
                endcase
                state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Occupancy follows the command issued this cycle.
    always_comb begin
        depth_d = depth_q;
        case (stackAction)
            SA_PUSH, SA_DUP: depth_d = depth_q + DW'(1);
            SA_POP:          depth_d = depth_q - DW'(1);
            default:         depth_d = depth_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign op_ready = (state_q == S_IDLE) && !rst;
    assign err      = err_q;
    assign depth    = depth_q;

endmodule

// File: tb/tb_stack_alu_seq.sv
// Testbench for stack_alu_seq with a behavioural stack model and
// table-driven op vectors plus fill, overflow and reset sequences.
module tb_stack_alu_seq;

    localparam int DW_ = 16;
    localparam int DP  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [3:0]    op_code = '0;
    logic [15:0]   op_imm = '0;
    logic [15:0]   top;
    logic [15:0]   next;
    logic [15:0]   in_val;
    logic [3:0]    stackAction;
    logic          done;
    logic          err;
    logic [4:0]    depth;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    stack_alu_seq #(.DATA_WIDTH(DW_), .DEPTH(DP)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_imm      (op_imm),
        .top         (top),
        .next        (next),
        .in_val      (in_val),
        .stackAction (stackAction),
        .done        (done),
        .err         (err),
        .depth       (depth)
    );

    // Behavioural stack reacting to the command encodings.
    logic [15:0] smem [0:31];
    int sp = 0;

    always @(posedge clk) begin
        if (rst) begin
            sp <= 0;
        end else begin
            case (stackAction)
                4'b1000: begin
                    smem[sp] <= in_val;
                    sp <= sp + 1;
                end
                4'b0001: if (sp > 0) sp <= sp - 1;
                4'b0101: if (sp > 0) begin
                    smem[sp] <= smem[sp-1];
                    sp <= sp + 1;
                end
                4'b0111: if (sp > 1) begin
                    smem[sp-1] <= smem[sp-2];
                    smem[sp-2] <= smem[sp-1];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        top  = (sp > 0) ? smem[sp-1] : 16'h0;
        next = (sp > 1) ? smem[sp-2] : 16'h0;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        else
            passed++;
    endtask

    // Issues one op and records latency, err and the non-idle actions.
    task automatic do_op(input logic [3:0] op, input logic [15:0] imm,
                         output logic got_err, output int lat,
                         output logic [15:0] acts);
        int n;
        bit fin;
        got_err = 1'b0;
        lat = 0;
        acts = '0;
        fin = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_code = op;
        op_imm = imm;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        n = 1;
        while (!fin && n < 20) begin
            if (stackAction != 4'b0000)
                acts = {acts[11:0], stackAction};
            if (done || err) begin
                got_err = err;
                lat = n;
                fin = 1;
                if (err) chk("ready_during_err", {31'd0, op_ready}, 32'd1);
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!fin) chk("op_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] imm;
        logic        e_err;
        int          e_lat;
        logic [15:0] e_acts;
        logic [15:0] e_top;
        int          e_depth;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic        ge;
        int          gl;
        logic [15:0] ga;

        vt.push_back('{4'h0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 0});
        vt.push_back('{4'hB, 16'h0001, 0, 2, 16'h0008, 16'h0001, 1});
        vt.push_back('{4'hB, 16'h0003, 0, 2, 16'h0008, 16'h0003, 2});
        vt.push_back('{4'h0, 16'h0000, 0, 6, 16'h0118, 16'h0004, 1});
        vt.push_back('{4'hA, 16'h0000, 0, 2, 16'h0001, 16'h0000, 0});
        vt.push_back('{4'hB, 16'h0007, 0, 2, 16'h0008, 16'h0007, 1});
        vt.push_back('{4'hB, 16'h0001, 0, 2, 16'h0008, 16'h0001, 2});
        vt.push_back('{4'h1, 16'h0000, 0, 6, 16'h0118, 16'h0006, 1});
        vt.push_back('{4'hA, 16'h0000, 0, 2, 16'h0001, 16'h0000, 0});
        vt.push_back('{4'hB, 16'h0007, 0, 2, 16'h0008, 16'h0007, 1});
        vt.push_back('{4'hB, 16'h0001, 0, 2, 16'h0008, 16'h0001, 2});
        vt.push_back('{4'h9, 16'h0000, 0, 2, 16'h0007, 16'h0007, 2});
        vt.push_back('{4'h1, 16'h0000, 0, 6, 16'h0118, 16'hFFFA, 1});
        vt.push_back('{4'hA, 16'h0000, 0, 2, 16'h0001, 16'h0000, 0});
        vt.push_back('{4'hB, 16'h8001, 0, 2, 16'h0008, 16'h8001, 1});
        vt.push_back('{4'h6, 16'h0000, 0, 4, 16'h0018, 16'h0002, 1});
        vt.push_back('{4'h7, 16'h0000, 0, 4, 16'h0018, 16'h0001, 1});
        vt.push_back('{4'h5, 16'h0000, 0, 4, 16'h0018, 16'hFFFE, 1});
        vt.push_back('{4'h8, 16'h0000, 0, 2, 16'h0005, 16'hFFFE, 2});
        vt.push_back('{4'h4, 16'h0000, 0, 6, 16'h0118, 16'h0000, 1});
        vt.push_back('{4'hC, 16'h0000, 1, 1, 16'h0000, 16'h0000, 1});
        vt.push_back('{4'h9, 16'h0000, 1, 1, 16'h0000, 16'h0000, 1});
        vt.push_back('{4'hA, 16'h0000, 0, 2, 16'h0001, 16'h0000, 0});
        vt.push_back('{4'h5, 16'h0000, 1, 1, 16'h0000, 16'h0000, 0});
        vt.push_back('{4'h8, 16'h0000, 1, 1, 16'h0000, 16'h0000, 0});
        vt.push_back('{4'hA, 16'h0000, 1, 1, 16'h0000, 16'h0000, 0});
        vt.push_back('{4'hB, 16'h0005, 0, 2, 16'h0008, 16'h0005, 1});
        vt.push_back('{4'hB, 16'h00F0, 0, 2, 16'h0008, 16'h00F0, 2});
        vt.push_back('{4'h2, 16'h0000, 0, 6, 16'h0118, 16'h0000, 1});
        vt.push_back('{4'hB, 16'h0F0A, 0, 2, 16'h0008, 16'h0F0A, 2});
        vt.push_back('{4'h3, 16'h0000, 0, 6, 16'h0118, 16'h0F0A, 1});
        vt.push_back('{4'hA, 16'h0000, 0, 2, 16'h0001, 16'h0000, 0});

        // Reset state
        @(negedge clk);
        chk("ready_in_rst", {31'd0, op_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, op_ready}, 32'd1);
        chk("rst_depth", {27'd0, depth}, 32'd0);
        chk("rst_action", {28'd0, stackAction}, 32'd0);
        chk("rst_inval", {16'd0, in_val}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);

        foreach (vt[i]) begin
            do_op(vt[i].op, vt[i].imm, ge, gl, ga);
            @(negedge clk);
            chk($sformatf("v%0d_err", i), {31'd0, ge}, {31'd0, vt[i].e_err});
            chk($sformatf("v%0d_lat", i), gl, vt[i].e_lat);
            chk($sformatf("v%0d_acts", i), {16'd0, ga}, {16'd0, vt[i].e_acts});
            chk($sformatf("v%0d_top", i), {16'd0, top}, {16'd0, vt[i].e_top});
            chk($sformatf("v%0d_depth", i), {27'd0, depth}, vt[i].e_depth);
        end

        // Fill to capacity, then overflow attempts.
        for (int i = 0; i < DP; i++) begin
            do_op(4'hB, 16'(i + 1), ge, gl, ga);
            chk("fill_err", {31'd0, ge}, 32'd0);
        end
        @(negedge clk);
        chk("full_depth", {27'd0, depth}, DP);
        chk("full_top", {16'd0, top}, DP);
        do_op(4'hB, 16'h1234, ge, gl, ga);
        chk("pushi_full_err", {31'd0, ge}, 32'd1);
        do_op(4'h8, 16'h0000, ge, gl, ga);
        chk("dup_full_err", {31'd0, ge}, 32'd1);
        @(negedge clk);
        chk("full_depth_kept", {27'd0, depth}, DP);

        // Reset during WAIT_A of an ADD.
        @(negedge clk);
        op_valid = 1'b1;
        op_code = 4'h0;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        chk("mid_pop_a", {28'd0, stackAction}, 32'h1);
        @(negedge clk);
        chk("mid_wait_a", {28'd0, stackAction}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_action", {28'd0, stackAction}, 32'h0);
        chk("mid_rst_depth", {27'd0, depth}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready", {31'd0, op_ready}, 32'd1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (done || stackAction != 4'b0000) seen++;
                @(negedge clk);
            end
            chk("mid_quiet", seen, 0);
        end
        chk("mid_depth_end", {27'd0, depth}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
